// File: rtl/tick_timeout_counter_pkg.sv
// Shared definitions for the seconds timeout counter: state encodings and defaults.
package tick_timeout_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

  localparam int CNT_W_DEFAULT   = 6;
  localparam int TIMEOUT_DEFAULT = 30;

endpackage

// File: rtl/tick_timeout_counter_sync_edge_detect.sv
// Two-flop synchronizer for a slow asynchronous level, plus an edge flop for a rise pulse.
module tick_timeout_counter_sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/tick_timeout_counter.sv
// Counts seconds down from a loaded window using ticks derived from the ~1 Hz divided clock.
module tick_timeout_counter
  import tick_timeout_counter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clock_div_i,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic [CNT_W-1:0] load_value_i,
  output logic [CNT_W-1:0] remaining_o,
  output logic             running_o,
  output logic             expired_o,
  output logic             timeout_o,
  output logic             blink_o
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             timeout_q, timeout_d;
  logic             div_level;
  logic             tick;
  logic [CNT_W-1:0] load_sel;

  tick_timeout_counter_sync_edge_detect u_sync (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .async_i (clock_div_i),
    .level_o (div_level),
    .rise_o  (tick)
  );

  assign load_sel = (load_value_i == '0) ? CNT_W'(TIMEOUT) : load_value_i;

  // cancel beats start, start beats tick (a tick in a reload cycle is dropped)
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timeout_d = 1'b0;
    if (cancel_i) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (start_i) begin
      state_d = ST_RUN;
      rem_d   = load_sel;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (rem_q > CNT_W'(1)) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              rem_d     = '0;
              state_d   = ST_EXPIRED;
              timeout_d = 1'b1;
            end
          end
        end
        ST_EXPIRED: rem_d = '0;
        ST_IDLE:    rem_d = '0;
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      running_q <= running_d;
      expired_q <= expired_d;
      timeout_q <= timeout_d;
    end
  end

  assign remaining_o = rem_q;
  assign running_o   = running_q;
  assign expired_o   = expired_q;
  assign timeout_o   = timeout_q;
  assign blink_o     = div_level & (running_q | expired_q);

endmodule

// File: tb/tb_tick_timeout_counter.sv
// Scoreboard bench for tick_timeout_counter: expectations queued with stimulus, drained at sample points.
module tb_tick_timeout_counter;

  localparam int CNT_W = 6;

  logic             clock, reset, clock_div, start, cancel;
  logic [CNT_W-1:0] load_value;
  logic [CNT_W-1:0] remaining;
  logic             running, expired, timeout, blink;

  int checks = 0;
  int failures = 0;
  int to_cnt = 0;
  int to_run = 0;
  int to_maxw = 0;

  typedef enum int {SEL_REM, SEL_RUN, SEL_EXP, SEL_BLINK, SEL_TOCNT, SEL_TOW} sel_e;
  typedef struct {
    string tag;
    sel_e  sel;
    int    exp;
  } exp_t;
  exp_t sb_q[$];

  tick_timeout_counter #(.CNT_W(CNT_W), .TIMEOUT(30)) u_dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .clock_div_i  (clock_div),
    .start_i      (start),
    .cancel_i     (cancel),
    .load_value_i (load_value),
    .remaining_o  (remaining),
    .running_o    (running),
    .expired_o    (expired),
    .timeout_o    (timeout),
    .blink_o      (blink)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (timeout === 1'b1) begin
      to_cnt++;
      to_run++;
      if (to_run > to_maxw) to_maxw = to_run;
    end else begin
      to_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sel_e sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_REM:   act = 32'(remaining);
        SEL_RUN:   act = 32'(running);
        SEL_EXP:   act = 32'(expired);
        SEL_BLINK: act = 32'(blink);
        SEL_TOCNT: act = 32'(to_cnt);
        default:   act = 32'(to_maxw);
      endcase
      chk(e.tag, act, 32'(e.exp));
    end
  endtask

  // called on a negedge; leaves the caller on a negedge
  task automatic div_high(input int n);
    clock_div = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic div_low(input int n);
    clock_div = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic div_period();
    div_high(8);
    div_low(8);
  endtask

  task automatic do_start(input int lv);
    load_value = CNT_W'(lv);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clock_div = 1'b1; start = 1'b0; cancel = 1'b0; load_value = '0;
    repeat (4) @(negedge clock);
    expect_val("reset_rem", SEL_REM, 0);
    expect_val("reset_run", SEL_RUN, 0);
    expect_val("reset_exp", SEL_EXP, 0);
    expect_val("reset_blink", SEL_BLINK, 0);
    drain();

    // 1: release with divided clock already high -> spurious edge only in IDLE
    reset = 1'b0;
    repeat (20) @(negedge clock);
    expect_val("t1_rem", SEL_REM, 0);
    expect_val("t1_run", SEL_RUN, 0);
    expect_val("t1_exp", SEL_EXP, 0);
    expect_val("t1_blink_idle", SEL_BLINK, 0);
    expect_val("t1_tocnt", SEL_TOCNT, 0);
    drain();
    div_low(8);

    // 2: window of 3 seconds
    do_start(3);
    expect_val("t2_load", SEL_REM, 3);
    expect_val("t2_running", SEL_RUN, 1);
    drain();
    div_high(4);
    expect_val("t2_blink_run", SEL_BLINK, 1);
    drain();
    div_high(4);
    div_low(8);
    expect_val("t2_rem_a", SEL_REM, 2);
    drain();
    div_period();
    expect_val("t2_rem_b", SEL_REM, 1);
    expect_val("t2_tocnt_pre", SEL_TOCNT, 0);
    drain();
    div_period();
    expect_val("t2_rem_c", SEL_REM, 0);
    expect_val("t2_expired", SEL_EXP, 1);
    expect_val("t2_run_off", SEL_RUN, 0);
    expect_val("t2_tocnt", SEL_TOCNT, 1);
    expect_val("t2_towidth", SEL_TOW, 1);
    drain();
    for (int i = 0; i < 2; i++) begin
      div_high(4);
      expect_val("t2_blink_exp", SEL_BLINK, 1);
      drain();
      div_high(4);
      div_low(8);
      expect_val("t2_exp_hold", SEL_EXP, 1);
      expect_val("t2_rem_hold", SEL_REM, 0);
      expect_val("t2_tocnt_hold", SEL_TOCNT, 1);
      drain();
    end

    // 3: default window from restart out of EXPIRED; latency of a single rise
    do_start(0);
    expect_val("t3_default", SEL_REM, 30);
    expect_val("t3_running", SEL_RUN, 1);
    drain();
    clock_div = 1'b1;
    @(negedge clock);
    expect_val("t3_no_early", SEL_REM, 30);
    drain();
    repeat (3) @(negedge clock);
    expect_val("t3_dec", SEL_REM, 29);
    drain();
    repeat (4) @(negedge clock);
    div_low(8);
    expect_val("t3_single", SEL_REM, 29);
    drain();

    // 4: reload in the tick cycle wins over the decrement
    do_start(2);
    clock_div = 1'b1;
    repeat (2) @(negedge clock);
    load_value = CNT_W'(5);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    div_low(8);
    expect_val("t4_reload", SEL_REM, 5);
    expect_val("t4_running", SEL_RUN, 1);
    drain();

    // 5: cancel beats start
    start = 1'b1; cancel = 1'b1; load_value = CNT_W'(7);
    @(negedge clock);
    start = 1'b0; cancel = 1'b0;
    expect_val("t5_rem", SEL_REM, 0);
    expect_val("t5_run", SEL_RUN, 0);
    expect_val("t5_exp", SEL_EXP, 0);
    expect_val("t5_tocnt", SEL_TOCNT, 1);
    drain();
    div_period();
    expect_val("t5_idle_noticks", SEL_REM, 0);
    drain();

    // 6: reset lands on the final tick of a 1 s window
    do_start(1);
    clock_div = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    expect_val("t6_rem", SEL_REM, 0);
    expect_val("t6_run", SEL_RUN, 0);
    expect_val("t6_exp", SEL_EXP, 0);
    expect_val("t6_blink_idle", SEL_BLINK, 0);
    drain();
    div_low(8);
    div_period();
    expect_val("t6_tocnt", SEL_TOCNT, 1);
    expect_val("t6_exp_late", SEL_EXP, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
